mips_cpu: RTL and testbench
===========================

# mips_cpu

Single-cycle 32-bit MIPS core (module `mips_cpu`, replaces `mips`) executing a fixed MIPS-I integer subset with no exceptions or delay slots. It connects to an external combinational-read instruction ROM and an external byte-enabled data RAM, and exports a per-cycle register-writeback trace port used by the system bench for golden-log comparison.

## Interface
- No parameters. Reset PC 0x0000_3000 is a package constant.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `i_inst_addr` out 32: byte address of the current instruction (PC).
- `i_inst_rdata` in 32: instruction word, combinational from `i_inst_addr`.
- `m_data_addr` out 32: data byte address (ALU result rs+sext(imm)).
- `m_data_rdata` in 32: word at `m_data_addr & ~3`, combinational.
- `m_data_wdata` out 32: store data, already shifted into the addressed byte lanes.
- `m_data_byteen` out 4: per-lane write enable; 0 when not storing; memory writes on the rising edge.
- `m_inst_addr` out 32: PC of the instruction driving the memory port (= PC).
- `w_grf_we` out 1: a GPR is written this cycle.
- `w_grf_addr` out 5: destination register.
- `w_grf_wdata` out 32: value written.
- `w_inst_addr` out 32: PC of the writing instruction (= PC).

## Operation
- State: PC (32) and a 32x32 GRF. $0 reads 0 and is never written.
- Supported: R-type `addu add subu sub and or nor xor slt sltu sll srl sra jr`; I-type `addi addiu andi ori xori lui slti sltiu beq bne lw lh lhu lb lbu sw sh sb`; J-type `j jal`. Any other encoding executes as NOP (PC+4, no writes).
- add/addi behave exactly as addu/addiu (wraparound, no overflow trap).
- Immediates: sign-extended for arithmetic, slti/sltiu, loads/stores, branches; zero-extended for andi/ori/xori; lui = imm<<16.
- Next PC: beq/bne taken → PC+4+(sext(imm)<<2); j/jal → {PC+4[31:28], index, 2'b00}; jr → rs; else PC+4. No delay slot.
- jal writes PC+4 to $31.
- Loads: byte lane chosen by addr[1:0] (half by addr[1]); lb/lh sign-extend, lbu/lhu zero-extend; lw ignores addr[1:0].
- Stores: sw byteen 4'b1111, wdata=rt; sh byteen 4'b0011<<(2*addr[1]), wdata={2{rt[15:0]}}; sb byteen 4'b0001<<addr[1:0], wdata={4{rt[7:0]}}.
- Trace: `w_grf_we`=1 iff the instruction writes a GPR and destination ≠ 0; addr/wdata mirror the GRF write port. When `w_grf_we`=0, addr/wdata are don't-care but held at 0.

## Timing
- One instruction per cycle; PC, GRF, and external memory all update on the same rising edge.
- Load data is combinational within the cycle; there are no stalls.
- While `reset`=0 at an edge: PC←0x3000 and all GRF←0. During a reset cycle, `m_data_byteen`=0 and `w_grf_we`=0, so the core causes no side effects.
- The first instruction executes in the cycle after `reset` goes 1. Reset asserted mid-program aborts the current instruction without any write.
- Reading a register written by the previous instruction returns the new value (GRF write at the edge, combinational read).

## Structure
- Package `mips_pkg`: opcode/funct localparams, `RESET_PC`, ALU-op and load/store-type enums.
- Sub-module `mips_grf` holds the 32x32 register file (2 async read ports, 1 sync write port, sync active-low clear). Decode, ALU, and load/store lane logic stay in the top level.

## Test plan
- Reset held low 3 cycles, then released → `i_inst_addr`=0x3000. No byteen or grf_we asserted during reset.
- `ori $1,$0,0x1234; lui $2,0xabcd; addu $3,$1,$2` → trace `$1<=00001234`, `$2<=abcd0000`, `$3<=abcd1234` at PCs 3000/3004/3008.
- `sw $3,4($0); sb $1,5($0); lh $4,4($0); lbu $5,5($0)` → byteen 1111 then 0010. Memory word1 = abcd3434. `$4<=00003434`, `$5<=00000034`.
- `beq $0,$0,+1` at 0x3000 → next PC 0x3008. `bne $0,$0,x` → 0x3004. `jal 0x3010` at 0x3008 → `$31<=0000300c`, PC 0x3010. `jr $31` → PC 0x300c.
- `addiu $0,$0,5` → no trace line and $0 stays 0. `slt` and `sltu` with $1=0xffffffff, $2=1 → 1 and 0 respectively.
- Undefined opcode 0xfc000000 → PC+4 with no register or memory writes.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the mips_cpu core.
// Opcodes, functs, reset PC and decode enums.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [2:0] {
    LD_NONE, LD_W, LD_H, LD_HU, LD_B, LD_BU
  } ld_e;

  typedef enum logic [1:0] {
    ST_NONE, ST_W, ST_H, ST_B
  } st_e;

  typedef enum logic [1:0] {
    DST_RD, DST_RT, DST_RA
  } dst_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    use_imm;
    logic    imm_zext;
    logic    rf_we;
    dst_e    dst;
    ld_e     ld;
    st_e     st;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    jr;
    logic    link;
  } ctrl_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_grf.sv
// mips_grf: 32x32 register file, two async reads,
// one sync write, sync active-low clear; $0 hardwired.
module mips_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  // Clear on reset, otherwise write any register but $0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS-I subset core.
// Decode, ALU and load/store lane logic live here.
module mips_cpu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  logic [31:0] pc, npc, pc_plus4, br_target;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_ext;
  logic [31:0] rs_data, rt_data, alu_b, alu_res;
  logic [31:0] ld_data, wb_data, st_wdata;
  logic [3:0]  st_be;
  logic [4:0]  dst_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        br_taken, grf_we;
  ctrl_t       ctrl;

  assign instr = i_inst_rdata;
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  assign imm_sext = sext16(imm);
  assign imm_ext  = ctrl.imm_zext
                  ? {16'h0, imm} : imm_sext;

  // Decode opcode/funct into control bundle.
  always_comb begin
    ctrl = '0;
    ctrl.alu_op = ALU_ADD;
    ctrl.dst    = DST_RD;
    ctrl.ld     = LD_NONE;
    ctrl.st     = ST_NONE;
    case (op)
      OP_RTYPE: begin
        ctrl.rf_we = 1'b1;
        case (funct)
          F_ADD, F_ADDU: ctrl.alu_op = ALU_ADD;
          F_SUB, F_SUBU: ctrl.alu_op = ALU_SUB;
          F_AND:  ctrl.alu_op = ALU_AND;
          F_OR:   ctrl.alu_op = ALU_OR;
          F_XOR:  ctrl.alu_op = ALU_XOR;
          F_NOR:  ctrl.alu_op = ALU_NOR;
          F_SLT:  ctrl.alu_op = ALU_SLT;
          F_SLTU: ctrl.alu_op = ALU_SLTU;
          F_SLL:  ctrl.alu_op = ALU_SLL;
          F_SRL:  ctrl.alu_op = ALU_SRL;
          F_SRA:  ctrl.alu_op = ALU_SRA;
          F_JR: begin
            ctrl.rf_we = 1'b0;
            ctrl.jr    = 1'b1;
          end
          default: ctrl.rf_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.rf_we   = 1'b1;
        ctrl.use_imm = 1'b1;
        ctrl.dst     = DST_RT;
        case (op)
          OP_SLTI:  ctrl.alu_op = ALU_SLT;
          OP_SLTIU: ctrl.alu_op = ALU_SLTU;
          OP_ANDI: begin
            ctrl.alu_op   = ALU_AND;
            ctrl.imm_zext = 1'b1;
          end
          OP_ORI: begin
            ctrl.alu_op   = ALU_OR;
            ctrl.imm_zext = 1'b1;
          end
          OP_XORI: begin
            ctrl.alu_op   = ALU_XOR;
            ctrl.imm_zext = 1'b1;
          end
          OP_LUI:  ctrl.alu_op = ALU_LUI;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        ctrl.rf_we   = 1'b1;
        ctrl.use_imm = 1'b1;
        ctrl.dst     = DST_RT;
        case (op)
          OP_LB:   ctrl.ld = LD_B;
          OP_LBU:  ctrl.ld = LD_BU;
          OP_LH:   ctrl.ld = LD_H;
          OP_LHU:  ctrl.ld = LD_HU;
          default: ctrl.ld = LD_W;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.use_imm = 1'b1;
        case (op)
          OP_SB:   ctrl.st = ST_B;
          OP_SH:   ctrl.st = ST_H;
          default: ctrl.st = ST_W;
        endcase
      end
      OP_BEQ: ctrl.beq  = 1'b1;
      OP_BNE: ctrl.bne  = 1'b1;
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump  = 1'b1;
        ctrl.link  = 1'b1;
        ctrl.rf_we = 1'b1;
        ctrl.dst   = DST_RA;
      end
      default: ;
    endcase
  end

  mips_grf u_grf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_data),
    .rd2   (rt_data),
    .we    (grf_we),
    .wa    (dst_addr),
    .wd    (wb_data)
  );

  assign alu_b = ctrl.use_imm ? imm_ext : rt_data;

  // ALU; shifts take rt and shamt, lui takes imm.
  always_comb begin
    alu_res = '0;
    case (ctrl.alu_op)
      ALU_ADD:  alu_res = rs_data + alu_b;
      ALU_SUB:  alu_res = rs_data - alu_b;
      ALU_AND:  alu_res = rs_data & alu_b;
      ALU_OR:   alu_res = rs_data | alu_b;
      ALU_XOR:  alu_res = rs_data ^ alu_b;
      ALU_NOR:  alu_res = ~(rs_data | alu_b);
      ALU_SLT:
        alu_res = {31'b0,
          $signed(rs_data) < $signed(alu_b)};
      ALU_SLTU:
        alu_res = {31'b0, rs_data < alu_b};
      ALU_SLL:  alu_res = rt_data << shamt;
      ALU_SRL:  alu_res = rt_data >> shamt;
      ALU_SRA:
        alu_res = $unsigned(
          $signed(rt_data) >>> shamt);
      ALU_LUI:  alu_res = {imm, 16'h0};
      default:  alu_res = '0;
    endcase
  end

  // Pick the addressed byte and half from the read word.
  always_comb begin
    ld_byte = m_data_rdata[7:0];
    case (alu_res[1:0])
      2'd1:    ld_byte = m_data_rdata[15:8];
      2'd2:    ld_byte = m_data_rdata[23:16];
      2'd3:    ld_byte = m_data_rdata[31:24];
      default: ld_byte = m_data_rdata[7:0];
    endcase
    ld_half = alu_res[1] ? m_data_rdata[31:16]
                         : m_data_rdata[15:0];
  end

  // Extend the selected lane per load type.
  always_comb begin
    ld_data = m_data_rdata;
    case (ctrl.ld)
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {24'h0, ld_byte};
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = m_data_rdata;
    endcase
  end

  // Store lane enables and replicated write data.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = rt_data;
    case (ctrl.st)
      ST_W: st_be = 4'b1111;
      ST_H: begin
        st_be    = alu_res[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rt_data[15:0]}};
      end
      ST_B: begin
        st_be    = 4'b0001 << alu_res[1:0];
        st_wdata = {4{rt_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Writeback source and destination select.
  always_comb begin
    wb_data = alu_res;
    if (ctrl.link) begin
      wb_data = pc_plus4;
    end else if (ctrl.ld != LD_NONE) begin
      wb_data = ld_data;
    end
    case (ctrl.dst)
      DST_RT:  dst_addr = rt;
      DST_RA:  dst_addr = 5'd31;
      default: dst_addr = rd;
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4
                   + {imm_sext[29:0], 2'b00};
  assign br_taken  =
    (ctrl.beq && (rs_data == rt_data)) ||
    (ctrl.bne && (rs_data != rt_data));

  // Next-PC select; sources are mutually exclusive.
  always_comb begin
    npc = pc_plus4;
    unique case (1'b1)
      ctrl.jr:   npc = rs_data;
      ctrl.jump:
        npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      br_taken:  npc = br_target;
      default:   npc = pc_plus4;
    endcase
  end

  // Program counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= npc;
    end
  end

  assign grf_we = reset && ctrl.rf_we
               && (dst_addr != 5'd0);

  assign i_inst_addr   = pc;
  assign m_inst_addr   = pc;
  assign w_inst_addr   = pc;
  assign m_data_addr   = alu_res;
  assign m_data_wdata  = st_wdata;
  assign m_data_byteen = reset ? st_be : 4'b0000;
  assign w_grf_we      = grf_we;
  assign w_grf_addr    = grf_we ? dst_addr : 5'd0;
  assign w_grf_wdata   = grf_we ? wb_data : 32'd0;

endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed and random programs checked
// cycle by cycle against an instruction-level model.
module tb_mips_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_inst_addr, i_inst_rdata;
  logic [31:0] m_data_addr, m_data_rdata;
  logic [31:0] m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata, w_inst_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rom  [64];
  logic [31:0] ram  [64];
  logic [31:0] mmem [64];
  logic [31:0] mreg [32];
  logic [31:0] mpc;

  logic        e_we;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_wdat, e_addr, e_npc;
  logic [3:0]  e_be;

  mips_cpu dut (
    .clk           (clk),
    .reset         (reset),
    .i_inst_addr   (i_inst_addr),
    .i_inst_rdata  (i_inst_rdata),
    .m_data_addr   (m_data_addr),
    .m_data_rdata  (m_data_rdata),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .w_grf_we      (w_grf_we),
    .w_grf_addr    (w_grf_addr),
    .w_grf_wdata   (w_grf_wdata),
    .w_inst_addr   (w_inst_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fetch(
    input logic [31:0] a
  );
    logic [31:0] off;
    off = a - 32'h3000;
    if (off < 32'd256) return rom[off[7:2]];
    return 32'h0;
  endfunction

  assign i_inst_rdata = fetch(i_inst_addr);
  assign m_data_rdata = ram[m_data_addr[7:2]];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (m_data_byteen[k]) begin
        ram[m_data_addr[7:2]][8*k +: 8]
          <= m_data_wdata[8*k +: 8];
      end
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @pc %h",
               tag, got, exp, mpc);
    end
  endtask

  function automatic logic [31:0] r_t(
    input logic [5:0] fn, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd,
    input logic [4:0] sa
  );
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_t(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] im
  );
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] j_t(
    input logic [5:0] op, input logic [31:0] tgt
  );
    return {op, tgt[27:2]};
  endfunction

  // Architectural effect of one instruction at mpc.
  task automatic model_eval();
    logic [31:0] ins, a, b, simm, zimm, w, p4, wd;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa, wa;
    logic [7:0]  bt;
    logic [15:0] hw;
    logic        wr;
    e_we = 0; e_wa = 0; e_wd = 0; e_be = 0;
    e_wdat = 0; e_addr = 0; e_npc = 32'h3000;
    if (!reset) return;
    ins = fetch(mpc);
    op = ins[31:26]; rs = ins[25:21];
    rt = ins[20:16]; rd = ins[15:11];
    sa = ins[10:6];  fn = ins[5:0];
    a = mreg[rs]; b = mreg[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    p4 = mpc + 4;
    e_npc = p4;
    e_addr = a + simm;
    w = mmem[e_addr[7:2]];
    bt = 8'(w >> (8 * int'(e_addr[1:0])));
    hw = e_addr[1] ? w[31:16] : w[15:0];
    wr = 1'b1; wa = rt; wd = 0;
    case (op)
      6'h00: begin
        wa = rd;
        case (fn)
          6'h20, 6'h21: wd = a + b;
          6'h22, 6'h23: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h26: wd = a ^ b;
          6'h27: wd = ~(a | b);
          6'h2a: wd = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h2b: wd = (a < b) ? 1 : 0;
          6'h00: wd = b << sa;
          6'h02: wd = b >> sa;
          6'h03: wd = $unsigned($signed(b) >>> sa);
          6'h08: begin wr = 0; e_npc = a; end
          default: wr = 0;
        endcase
      end
      6'h02: begin
        wr = 0;
        e_npc = {p4[31:28], ins[25:0], 2'b00};
      end
      6'h03: begin
        e_npc = {p4[31:28], ins[25:0], 2'b00};
        wa = 31; wd = p4;
      end
      6'h04: begin
        wr = 0;
        if (a == b) e_npc = p4 + (simm << 2);
      end
      6'h05: begin
        wr = 0;
        if (a != b) e_npc = p4 + (simm << 2);
      end
      6'h08, 6'h09: wd = a + simm;
      6'h0a: wd = ($signed(a) < $signed(simm)) ? 1 : 0;
      6'h0b: wd = (a < simm) ? 1 : 0;
      6'h0c: wd = a & zimm;
      6'h0d: wd = a | zimm;
      6'h0e: wd = a ^ zimm;
      6'h0f: wd = {ins[15:0], 16'h0};
      6'h20: wd = {{24{bt[7]}}, bt};
      6'h24: wd = {24'h0, bt};
      6'h21: wd = {{16{hw[15]}}, hw};
      6'h25: wd = {16'h0, hw};
      6'h23: wd = w;
      6'h2b: begin
        wr = 0; e_be = 4'b1111; e_wdat = b;
      end
      6'h29: begin
        wr = 0; e_wdat = {2{b[15:0]}};
        e_be = e_addr[1] ? 4'b1100 : 4'b0011;
      end
      6'h28: begin
        wr = 0; e_wdat = {4{b[7:0]}};
        e_be = 4'(4'b0001 << e_addr[1:0]);
      end
      default: wr = 0;
    endcase
    if (wr && wa != 0) begin
      e_we = 1; e_wa = wa; e_wd = wd;
    end
  endtask

  task automatic model_commit();
    if (!reset) begin
      mpc = 32'h3000;
      for (int i = 0; i < 32; i++) mreg[i] = 0;
      return;
    end
    if (e_we) mreg[e_wa] = e_wd;
    for (int k = 0; k < 4; k++) begin
      if (e_be[k])
        mmem[e_addr[7:2]][8*k +: 8] = e_wdat[8*k +: 8];
    end
    mpc = e_npc;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    chk("pc", i_inst_addr, mpc);
    chk("m_pc", m_inst_addr, mpc);
    chk("w_pc", w_inst_addr, mpc);
    chk("we", {31'b0, w_grf_we}, {31'b0, e_we});
    chk("wa", {27'b0, w_grf_addr}, {27'b0, e_wa});
    chk("wd", w_grf_wdata, e_wd);
    chk("be", {28'b0, m_data_byteen}, {28'b0, e_be});
    if (e_be != 0) begin
      chk("wdata", m_data_wdata, e_wdat);
      chk("daddr", m_data_addr, e_addr);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic dstep(
    input logic [31:0] pc, input logic we,
    input logic [4:0] wa, input logic [31:0] wd,
    input logic [3:0] be
  );
    settle();
    chk("d_pc", i_inst_addr, pc);
    chk("d_we", {31'b0, w_grf_we}, {31'b0, we});
    if (we) begin
      chk("d_wa", {27'b0, w_grf_addr}, {27'b0, wa});
      chk("d_wd", w_grf_wdata, wd);
    end
    chk("d_be", {28'b0, m_data_byteen}, {28'b0, be});
    adv();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] al [10] = '{6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [5:0] sf [3] = '{6'h00, 6'h02, 6'h03};
    logic [5:0] ia [8] = '{6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0e, 6'h0f};
    logic [5:0] lo [5] = '{6'h20, 6'h21, 6'h23, 6'h24,
      6'h25};
    logic [5:0] so [3] = '{6'h28, 6'h29, 6'h2b};
    logic [4:0] r1, r2, r3;
    r1 = 5'($urandom); r2 = 5'($urandom);
    r3 = 5'($urandom);
    case ($urandom_range(0, 15))
      0, 1, 2, 15:
        return r_t(al[$urandom_range(0, 9)], r1, r2, r3,
                   5'($urandom));
      3: return r_t(sf[$urandom_range(0, 2)], r1, r2, r3,
                    5'($urandom));
      4, 5, 6:
        return i_t(ia[$urandom_range(0, 7)], r1, r2,
                   16'($urandom));
      7, 8:
        return i_t(lo[$urandom_range(0, 4)], 5'd0, r2,
                   16'($urandom_range(0, 255)));
      9, 10:
        return i_t(so[$urandom_range(0, 2)], 5'd0, r2,
                   16'($urandom_range(0, 255)));
      11:
        return i_t($urandom_range(0, 1) ? 6'h04 : 6'h05,
                   5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   16'($urandom_range(0, 8) - 4));
      12:
        return j_t($urandom_range(0, 1) ? 6'h02 : 6'h03,
                   32'h3000 + 4 * $urandom_range(0, 63));
      13: return r_t(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
      default:
        return {6'h3f, 26'($urandom)};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      mmem[i] = ram[i];
      rom[i] = 0;
    end
    rom[0]  = i_t(6'h0d, 0, 1, 16'h1234);
    rom[1]  = i_t(6'h0f, 0, 2, 16'habcd);
    rom[2]  = r_t(6'h21, 1, 2, 3, 0);
    rom[3]  = i_t(6'h2b, 0, 3, 16'd4);
    rom[4]  = i_t(6'h28, 0, 1, 16'd5);
    rom[5]  = i_t(6'h21, 0, 4, 16'd4);
    rom[6]  = i_t(6'h24, 0, 5, 16'd5);
    rom[7]  = i_t(6'h09, 0, 0, 16'd5);
    rom[8]  = i_t(6'h09, 0, 6, 16'hffff);
    rom[9]  = i_t(6'h09, 0, 7, 16'd1);
    rom[10] = r_t(6'h2a, 6, 7, 8, 0);
    rom[11] = r_t(6'h2b, 6, 7, 9, 0);
    rom[12] = 32'hfc000000;

    reset = 1'b0;
    @(posedge clk);
    #1;
    mpc = 32'h3000;
    for (int i = 0; i < 32; i++) mreg[i] = 0;
    settle(); adv();
    settle(); adv();
    reset = 1'b1;

    dstep(32'h3000, 1, 1, 32'h00001234, 4'h0);
    dstep(32'h3004, 1, 2, 32'habcd0000, 4'h0);
    dstep(32'h3008, 1, 3, 32'habcd1234, 4'h0);
    dstep(32'h300c, 0, 0, 32'h0, 4'hf);
    dstep(32'h3010, 0, 0, 32'h0, 4'h2);
    dstep(32'h3014, 1, 4, 32'h00003434, 4'h0);
    dstep(32'h3018, 1, 5, 32'h00000034, 4'h0);
    dstep(32'h301c, 0, 0, 32'h0, 4'h0);
    dstep(32'h3020, 1, 6, 32'hffffffff, 4'h0);
    dstep(32'h3024, 1, 7, 32'h00000001, 4'h0);
    dstep(32'h3028, 1, 8, 32'h00000001, 4'h0);
    dstep(32'h302c, 1, 9, 32'h00000000, 4'h0);
    dstep(32'h3030, 0, 0, 32'h0, 4'h0);
    dstep(32'h3034, 0, 0, 32'h0, 4'h0);
    chk("word1", ram[1], 32'habcd3434);

    reset = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 0;
    rom[0] = i_t(6'h04, 0, 0, 16'd1);
    rom[2] = j_t(6'h03, 32'h3010);
    rom[3] = i_t(6'h05, 0, 0, 16'd5);
    rom[4] = r_t(6'h08, 31, 0, 0, 0);
    settle(); adv();
    reset = 1'b1;
    dstep(32'h3000, 0, 0, 32'h0, 4'h0);
    dstep(32'h3008, 1, 31, 32'h0000300c, 4'h0);
    dstep(32'h3010, 0, 0, 32'h0, 4'h0);
    dstep(32'h300c, 0, 0, 32'h0, 4'h0);
    dstep(32'h3010, 0, 0, 32'h0, 4'h0);

    for (int r = 0; r < 8; r++) begin
      reset = 1'b0;
      for (int i = 0; i < 64; i++) rom[i] = rand_ins();
      for (int c = $urandom_range(1, 3); c > 0; c--) begin
        settle(); adv();
      end
      reset = 1'b1;
      for (int c = 0; c < 300; c++) begin
        settle(); adv();
      end
    end

    for (int i = 0; i < 64; i++) begin
      chk("ram", ram[i], mmem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
